// File: rtl/bram_read_streamer.sv
// bram_read_streamer: burst reads from a 1-cycle-latency block RAM streamed through a credit-gated 2-entry buffer
module bram_read_streamer #(
  parameter int width = 4,
  parameter int depth = 1024,
  localparam int AW = $clog2(depth)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start__ENA,
  input  logic [AW-1:0]    start_base,
  input  logic [AW:0]      start_count,
  output logic             start__RDY,
  output logic             ramRead__ENA,
  output logic [AW-1:0]    ramRead_addr,
  input  logic             ramRead__RDY,
  input  logic [width-1:0] ramData,
  input  logic             ramData__RDY,
  output logic             out__ENA,
  output logic [width-1:0] out_data,
  output logic             out_last,
  input  logic             out__RDY,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  logic [1:0]       r_state;
  logic [AW-1:0]    r_addr;
  logic [AW:0]      r_issue_left;
  logic [AW:0]      r_deliver_left;
  logic             r_inflight;
  logic [1:0]       r_occ;
  logic [width-1:0] r_b0;
  logic [width-1:0] r_b1;
  logic             w_fire;
  logic             w_issue;
  logic             w_push;
  logic [2:0]       w_credit;
  logic [1:0]       w_wr_idx;
  assign w_fire   = (r_occ != 2'd0) && out__RDY;
  assign w_credit = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_fire};
  assign w_issue  = (r_state == S_RUN) && (r_issue_left != '0) && ramRead__RDY && (w_credit < 3'd2);
  assign w_push   = ramData__RDY && r_inflight;
  assign w_wr_idx = r_occ - {1'b0, w_fire};
  assign start__RDY   = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign ramRead__ENA = w_issue;
  assign ramRead_addr = r_addr;
  assign out__ENA     = (r_occ != 2'd0);
  assign out_data     = out__ENA ? r_b0 : '0;
  assign out_last     = out__ENA && (r_deliver_left == ONE);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_issue_left   <= '0;
      r_deliver_left <= '0;
      r_inflight     <= 1'b0;
      r_occ          <= 2'd0;
      r_b0           <= '0;
      r_b1           <= '0;
    end else begin
      r_inflight <= w_issue;
      r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_fire};
      if (w_push && w_wr_idx == 2'd0) r_b0 <= ramData;
      else if (w_fire) r_b0 <= r_b1;
      if (w_push && w_wr_idx == 2'd1) r_b1 <= ramData;
      if (w_issue) begin
        r_addr       <= (r_addr == AW'(depth - 1)) ? '0 : r_addr + 1'b1;
        r_issue_left <= r_issue_left - ONE;
      end
      if (w_fire) r_deliver_left <= r_deliver_left - ONE;
      case (r_state)
        S_IDLE: if (start__ENA && start_count != '0) begin
          r_addr         <= start_base;
          r_issue_left   <= start_count;
          r_deliver_left <= start_count;
          r_state        <= S_RUN;
        end
        S_RUN:   if (w_issue && r_issue_left == ONE) r_state <= S_DRAIN;
        S_DRAIN: if (w_fire && r_deliver_left == ONE) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always @(posedge CLK)
    if (nRST) assert (!(w_push && r_occ == 2'd2 && !w_fire)) else $error("bram_read_streamer: output buffer overflow");
endmodule

// File: tb/tb_bram_read_streamer.sv
// tb_bram_read_streamer: directed bursts against a 1-cycle-latency RAM model whose data is the low 4 address bits.
module tb_bram_read_streamer;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_start = 1'b0;
    logic [9:0]  a_base = '0;
    logic [10:0] a_count = '0;
    logic        a_srdy, a_ren, a_oen, a_olast, a_busy;
    logic [9:0]  a_raddr;
    logic        a_rrdy = 1'b1;
    logic [3:0]  a_rdata = '0;
    logic        a_dvalid = 1'b0;
    logic [3:0]  a_odata;
    logic        a_ordy = 1'b1;

    logic        b_start = 1'b0;
    logic [3:0]  b_base = '0;
    logic [4:0]  b_count = '0;
    logic        b_srdy, b_ren, b_oen, b_olast, b_busy;
    logic [3:0]  b_raddr;
    logic        b_rrdy = 1'b1;
    logic [3:0]  b_rdata = '0;
    logic        b_dvalid = 1'b0;
    logic [3:0]  b_odata;
    logic        b_ordy = 1'b1;

    logic [5:0]  pat = 6'b101001;
    int n_chk = 0;
    int n_pass = 0;

    bram_read_streamer #(.width(4), .depth(1024)) u_a (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(a_start), .start_base(a_base), .start_count(a_count), .start__RDY(a_srdy),
        .ramRead__ENA(a_ren), .ramRead_addr(a_raddr), .ramRead__RDY(a_rrdy),
        .ramData(a_rdata), .ramData__RDY(a_dvalid),
        .out__ENA(a_oen), .out_data(a_odata), .out_last(a_olast), .out__RDY(a_ordy),
        .busy(a_busy)
    );

    bram_read_streamer #(.width(4), .depth(16)) u_b (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(b_start), .start_base(b_base), .start_count(b_count), .start__RDY(b_srdy),
        .ramRead__ENA(b_ren), .ramRead_addr(b_raddr), .ramRead__RDY(b_rrdy),
        .ramData(b_rdata), .ramData__RDY(b_dvalid),
        .out__ENA(b_oen), .out_data(b_odata), .out_last(b_olast), .out__RDY(b_ordy),
        .busy(b_busy)
    );

    always @(posedge CLK) begin
        a_dvalid <= a_ren;
        a_rdata  <= a_raddr[3:0];
        b_dvalid <= b_ren;
        b_rdata  <= b_raddr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic run_a(input logic [9:0] base, input logic [10:0] cnt, input bit bp, input bit inject, input string tag);
        int is, dl, first, lastc, maxo;
        bit bad_comp, bad_rrdy;
        is = 0; dl = 0; first = -1; lastc = -1; maxo = 0; bad_comp = 0; bad_rrdy = 0;
        @(negedge CLK);
        #1 chk({tag, "_srdy_pre"}, 32'(a_srdy), 1);
        a_base = base; a_count = cnt; a_start = 1'b1;
        for (int c = 0; c < 8 * int'(cnt) + 20 && dl < int'(cnt); c++) begin
            @(negedge CLK);
            a_start = inject && c == 3;
            a_base  = 10'd500;
            a_count = 11'd3;
            a_ordy  = bp ? pat[c % 6] : 1'b1;
            a_rrdy  = bp ? (c % 5 != 2) : 1'b1;
            #1;
            if (is - dl > maxo) maxo = is - dl;
            if (a_srdy === a_busy) bad_comp = 1;
            if (a_ren && !a_rrdy) bad_rrdy = 1;
            if (a_ren) begin
                chk({tag, "_addr"}, 32'(a_raddr), 32'((int'(base) + is) % 1024));
                is++;
            end
            if (a_oen && first < 0) first = c;
            if (a_oen && a_ordy) begin
                chk({tag, "_data"}, 32'(a_odata), 32'(((int'(base) + dl) % 1024) & 15));
                chk({tag, "_last"}, 32'(a_olast), 32'(dl == int'(cnt) - 1));
                dl++;
                lastc = c;
            end
        end
        a_start = 1'b0; a_ordy = 1'b1; a_rrdy = 1'b1;
        chk({tag, "_delivered"}, 32'(dl), 32'(cnt));
        chk({tag, "_issued"}, 32'(is), 32'(cnt));
        chk({tag, "_max_outstanding_le2"}, 32'(maxo <= 2), 1);
        chk({tag, "_rdy_busy_complement"}, 32'(bad_comp), 0);
        chk({tag, "_issue_only_when_ram_rdy"}, 32'(bad_rrdy), 0);
        if (!bp) begin
            chk({tag, "_first_valid_cycle"}, 32'(first), 2);
            chk({tag, "_last_xfer_cycle"}, 32'(lastc), 32'(int'(cnt) + 1));
        end
        @(negedge CLK);
        #1;
        chk({tag, "_srdy_post"}, 32'(a_srdy), 1);
        chk({tag, "_busy_post"}, 32'(a_busy), 0);
        chk({tag, "_oen_post"}, 32'(a_oen), 0);
    endtask

    initial begin
        int dl, is;
        bit bad;
        logic [15:0] mask;
        #1;
        chk("reset_srdy", 32'(a_srdy), 1);
        chk("reset_busy", 32'(a_busy), 0);
        chk("reset_ren", 32'(a_ren), 0);
        chk("reset_oen", 32'(a_oen), 0);
        chk("reset_last", 32'(a_olast), 0);
        chk("reset_data", 32'(a_odata), 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        run_a(10'd0, 11'd4, 1'b0, 1'b0, "basic");
        run_a(10'd1022, 11'd4, 1'b0, 1'b0, "wrap");
        run_a(10'd100, 11'd8, 1'b1, 1'b0, "backpressure");
        run_a(10'd40, 11'd8, 1'b0, 1'b1, "busy_start");

        @(negedge CLK);
        a_base = 10'd3; a_count = 11'd0; a_start = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            a_start = 1'b0;
            #1;
            if (a_ren || a_oen || !a_srdy) bad = 1;
        end
        chk("count0_noop", 32'(bad), 0);

        @(negedge CLK);
        a_base = 10'd0; a_count = 11'd8; a_start = 1'b1;
        dl = 0;
        for (int c = 0; c < 40 && dl < 3; c++) begin
            @(negedge CLK);
            a_start = 1'b0;
            #1;
            if (a_oen && a_ordy) dl++;
        end
        @(negedge CLK);
        #1 chk("midrst_dvalid_high", 32'(a_dvalid), 1);
        nRST = 1'b0;
        #1;
        chk("midrst_srdy", 32'(a_srdy), 1);
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_ren", 32'(a_ren), 0);
        chk("midrst_oen", 32'(a_oen), 0);
        chk("midrst_last", 32'(a_olast), 0);
        chk("midrst_data", 32'(a_odata), 0);
        #1 nRST = 1'b1;
        @(negedge CLK);
        #1 chk("stale_dvalid_no_out", 32'(a_oen), 0);
        @(negedge CLK);
        #1 chk("stale_dvalid_no_out2", 32'(a_oen), 0);
        run_a(10'd5, 11'd2, 1'b0, 1'b0, "post_reset");

        @(negedge CLK);
        b_base = 4'd7; b_count = 5'd16; b_start = 1'b1;
        dl = 0; is = 0; mask = '0;
        for (int c = 0; c < 80 && dl < 16; c++) begin
            @(negedge CLK);
            b_start = 1'b0;
            #1;
            if (b_ren) begin
                chk("full_addr", 32'(b_raddr), 32'((7 + is) % 16));
                mask = mask | (16'd1 << b_raddr);
                is++;
            end
            if (b_oen && b_ordy) begin
                chk("full_data", 32'(b_odata), 32'((7 + dl) % 16));
                chk("full_last", 32'(b_olast), 32'(dl == 15));
                dl++;
            end
        end
        chk("full_mask", 32'(mask), 32'hFFFF);
        chk("full_issued", 32'(is), 16);
        chk("full_delivered", 32'(dl), 16);
        @(negedge CLK);
        #1 chk("full_srdy_post", 32'(b_srdy), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bram_read_streamer.md
# bram_read_streamer

Read-side sequencer that sits directly downstream of the single-port block RAM. It accepts a burst request (base address, element count) and issues one RAM read per cycle, with wrap-around at `depth`. It captures the RAM's one-cycle-latency read data and presents it as a valid/ready stream with a `last` marker. A 2-entry output buffer with credit-based issue gives full 1-element/cycle throughput under backpressure, with no data loss.

## Interface
Parameters:
- `width`, 4, data element width in bits; must match the RAM.
- `depth`, 1024, RAM depth in elements. AW = $clog2(depth).

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `nRST`  in  1  reset, asynchronous assert, active-low.
- `start__ENA`  in  1  burst request; accepted when high with `start__RDY`.
- `start$base`  in  AW  first RAM address.
- `start$count`  in  AW+1  number of elements, 0..depth.
- `start__RDY`  out  1  high only in IDLE.
- `ramRead__ENA`  out  1  read strobe to RAM.
- `ramRead$addr`  out  AW  read address.
- `ramRead__RDY`  in  1  RAM read ready; reads are issued only when high.
- `ramData`  in  width  RAM read data.
- `ramData__RDY`  in  1  RAM data-valid; high the cycle after a read strobe.
- `out__ENA`  out  1  output valid.
- `out$data`  out  width  output element.
- `out$last`  out  1  high with the final element of a burst.
- `out__RDY`  in  1  consumer ready. Transfer occurs when `out__ENA` and `out__RDY` are both high.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- Reset (nRST low, asynchronous):
  - state=IDLE; addr, remaining-to-issue, remaining-to-deliver, inflight, buffer occupancy all 0.
  - Outputs: `start__RDY`=1, `busy`=0, `ramRead__ENA`=0, `out__ENA`=0, `out$last`=0, `out$data`=0.
- FSM states and transitions:
  - IDLE:
    - Start accept with count=0: no-op; remain IDLE.
    - Start accept with count>0: load addr=base, issueLeft=count, deliverLeft=count; go to RUN.
  - RUN:
    - Issue a read each cycle the issue condition holds.
    - When issueLeft reaches 0, go to DRAIN.
  - DRAIN:
    - No issue.
    - When deliverLeft reaches 0 (last element transferred), go to IDLE.
- Issue condition (combinational): state==RUN, issueLeft>0, `ramRead__RDY`, and `occ + inflight - outFire < 2`.
  - occ is buffer entries 0..2; inflight is 0/1; outFire is this-cycle transfer.
- On issue:
  - `ramRead$addr`=addr.
  - addr ← (addr==depth-1) ? 0 : addr+1. Explicit wrap; do not rely on power-of-two overflow.
  - issueLeft−−; inflight ← 1. No issue that cycle → inflight ← 0.
- Capture: when `ramData__RDY` and inflight==1, push `ramData` into the buffer tail.
  - `ramData__RDY` with inflight==0 is ignored. This covers stale RAM valid after reset.
- Buffer: 2-entry FIFO; head drives `out$data`; `out__ENA`=(occ>0).
  - Push and pop in the same cycle are legal; occ is unchanged.
  - The credit rule guarantees push never occurs with occ==2 and no pop. Overflow is a design error; assert it in simulation.
- `out$last` = `out__ENA` and deliverLeft==1.
- On transfer: deliverLeft−−.
- `start__ENA` while not IDLE is ignored (`start__RDY`=0).
- count==depth: every address is read exactly once, starting at base, wrapping through depth-1→0.

## Timing
- Start sampled at edge E0 → RUN after E0 → first `ramRead__ENA` in cycle E0..E1.
  - RAM registers data at E1.
  - `ramData__RDY` high E1..E2; captured at E2.
  - `out__ENA` high from E2. Start-to-first-valid = 2 cycles.
- With `out__RDY` held high and `ramRead__RDY`=1: one transfer per cycle. An N-element burst completes its last transfer at edge E(N+1).
- `start__RDY` rises in the cycle after the edge that transfers the `last` element. A new start is accepted at the next edge; there is no back-to-back overlap.
- Backpressure (`out__RDY` low): issue stalls within one cycle; at most 2 elements are held; no element is dropped or duplicated.
- `busy` and `start__RDY` are complementary at all times.

## Test plan
- Basic burst: RAM[i]=i; start base=0, count=4, `out__RDY`=1.
  - Outputs 0,1,2,3 on 4 consecutive cycles starting 2 cycles after accept.
  - `last` only on 3; `start__RDY` high the cycle after.
- Wrap: depth=1024, base=1022, count=4 → addresses 1022,1023,0,1; data matches RAM.
- Backpressure: count=8; `out__RDY` toggles 1,0,0,1,0,1,…
  - All 8 values are delivered in order, none lost or duplicated.
  - Never more than 2 outstanding (occ+inflight ≤ 2).
- Count 0 and busy start: count=0 → no `ramRead__ENA` and no output, `start__RDY` stays 1.
  - A start pulse during a running burst is ignored.
- Reset mid-burst: assert nRST low after 3 of 8 transfers while `ramData__RDY` is high.
  - All outputs return to reset values immediately.
  - After release, the stale `ramData__RDY` produces no output.
  - A new burst base=5, count=2 yields RAM[5], RAM[6].
- Full-depth: depth=16, base=7, count=16 → all 16 addresses each read once, 16 transfers, `last` on address 6.
